// File: rtl/pdu_imem_loader.sv
// pdu_imem_loader: packs a little-endian byte stream into 32-bit IMEM word writes.
// Define PDU_IMEM_LOADER_CHECKSUM_EN to require a trailing 32-bit sum of the written words.
module pdu_imem_loader #(
  parameter int DEPTH = 12
) (
  input  logic             sys_clk,
  input  logic             sys_rstn,
  input  logic             load_start,
  input  logic [DEPTH-1:0] load_base,
  input  logic [DEPTH:0]   load_count,
  input  logic             load_abort,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             rx_ready,
  output logic             mem_we,
  output logic [DEPTH-1:0] mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic             error
);

`ifdef PDU_IMEM_LOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECV, WRITE, CHECK, DONE} state_t;
`else
  typedef enum logic [2:0] {IDLE, RECV, WRITE, DONE} state_t;
`endif

  state_t           state;
  state_t           state_next;
  logic [DEPTH-1:0] base_q;
  logic [DEPTH:0]   count_q;
  logic [DEPTH:0]   idx;
  logic [DEPTH:0]   idx_inc;
  logic [1:0]       byte_idx;
  logic [23:0]      shift;
  logic [31:0]      word;
  logic             accept;
  logic             last_byte;
  logic             aborting;
`ifdef PDU_IMEM_LOADER_CHECKSUM_EN
  logic [31:0]      sum;
`endif

  // The three earlier bytes sit in shift, so the incoming byte completes the word.
  assign word      = {rx_data, shift};
  assign idx_inc   = idx + 1'b1;
  assign aborting  = load_abort && (state != IDLE);
  assign busy      = (state != IDLE);
  assign accept    = rx_valid && rx_ready;
  assign last_byte = accept && (byte_idx == 2'd3);

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) state <= IDLE;
    else           state <= state_next;
  end

  always_comb begin
    state_next = state;
    rx_ready   = 1'b0;
    mem_we     = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE: begin
        if (load_start) state_next = (load_count == '0) ? DONE : RECV;
      end
      RECV: begin
        rx_ready = 1'b1;
        if (rx_valid && (byte_idx == 2'd3)) state_next = WRITE;
      end
      WRITE: begin
        mem_we = 1'b1;
        if (idx_inc < count_q) state_next = RECV;
`ifdef PDU_IMEM_LOADER_CHECKSUM_EN
        else                   state_next = CHECK;
`else
        else                   state_next = DONE;
`endif
      end
`ifdef PDU_IMEM_LOADER_CHECKSUM_EN
      CHECK: begin
        rx_ready = 1'b1;
        if (rx_valid && (byte_idx == 2'd3)) state_next = (word == sum) ? DONE : IDLE;
      end
`endif
      DONE: begin
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    // Abort overrides any handshake, write strobe or completion in the same cycle.
    if (aborting) begin
      state_next = IDLE;
      rx_ready   = 1'b0;
      mem_we     = 1'b0;
      done       = 1'b0;
    end
  end

  always_ff @(posedge sys_clk or negedge sys_rstn) begin
    if (!sys_rstn) begin
      base_q    <= '0;
      count_q   <= '0;
      idx       <= '0;
      byte_idx  <= '0;
      shift     <= '0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      error     <= 1'b0;
`ifdef PDU_IMEM_LOADER_CHECKSUM_EN
      sum       <= '0;
`endif
    end else if (aborting) begin
      error    <= 1'b1;
      byte_idx <= '0;
    end else begin
      if ((state == IDLE) && load_start) begin
        base_q   <= load_base;
        count_q  <= load_count;
        idx      <= '0;
        byte_idx <= '0;
        error    <= 1'b0;
`ifdef PDU_IMEM_LOADER_CHECKSUM_EN
        sum      <= '0;
`endif
      end
      if (accept) begin
        byte_idx <= byte_idx + 2'd1;
        shift    <= {rx_data, shift[23:8]};
      end
      // Address and data are registered one cycle ahead so they are stable while mem_we is high.
      if ((state == RECV) && last_byte) begin
        mem_addr  <= base_q + idx[DEPTH-1:0];
        mem_wdata <= word;
      end
      if (mem_we) begin
        idx <= idx_inc;
`ifdef PDU_IMEM_LOADER_CHECKSUM_EN
        sum <= sum + mem_wdata;
`endif
      end
`ifdef PDU_IMEM_LOADER_CHECKSUM_EN
      if ((state == CHECK) && last_byte && (word != sum)) error <= 1'b1;
`endif
    end
  end

endmodule

// File: tb/tb_pdu_imem_loader.sv
// tb_pdu_imem_loader: randomized byte-stream loads checked by a write/done scoreboard.
// Follows PDU_IMEM_LOADER_CHECKSUM_EN so the checksum trailer is exercised when defined.
module tb_pdu_imem_loader;
  localparam int DEPTH = 12;

  typedef struct {
    bit               is_done;
    logic [DEPTH-1:0] addr;
    logic [31:0]      data;
  } exp_t;

  logic             sys_clk    = 1'b0;
  logic             sys_rstn   = 1'b0;
  logic             load_start = 1'b0;
  logic [DEPTH-1:0] load_base  = '0;
  logic [DEPTH:0]   load_count = '0;
  logic             load_abort = 1'b0;
  logic             rx_valid   = 1'b0;
  logic [7:0]       rx_data    = '0;
  logic             rx_ready;
  logic             mem_we;
  logic [DEPTH-1:0] mem_addr;
  logic [31:0]      mem_wdata;
  logic             busy;
  logic             done;
  logic             error;

  exp_t       exp_q[$];
  exp_t       got;
  logic [7:0] stim_bytes[$];
  int         n_checks  = 0;
  int         n_fail    = 0;
  bit         saw_ready = 1'b0;

  pdu_imem_loader #(.DEPTH(DEPTH)) dut (
    .sys_clk   (sys_clk),
    .sys_rstn  (sys_rstn),
    .load_start(load_start),
    .load_base (load_base),
    .load_count(load_count),
    .load_abort(load_abort),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_ready  (rx_ready),
    .mem_we    (mem_we),
    .mem_addr  (mem_addr),
    .mem_wdata (mem_wdata),
    .busy      (busy),
    .done      (done),
    .error     (error)
  );

  always #5 sys_clk = ~sys_clk;

  task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Monitor: every write strobe and done pulse must match the head of the scoreboard.
  always @(negedge sys_clk) begin
    #1;
    if (sys_rstn) begin
      if (rx_ready) saw_ready = 1'b1;
      if (mem_we) begin
        check_output("write_expected", 32'(exp_q.size() != 0 && !exp_q[0].is_done), 32'd1);
        if (exp_q.size() != 0 && !exp_q[0].is_done) begin
          got = exp_q.pop_front();
          check_output("write_addr", 32'(mem_addr), 32'(got.addr));
          check_output("write_data", mem_wdata, got.data);
        end
      end
      if (done) begin
        check_output("done_expected", 32'(exp_q.size() != 0 && exp_q[0].is_done), 32'd1);
        if (exp_q.size() != 0 && exp_q[0].is_done) got = exp_q.pop_front();
      end
    end
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL global_timeout: got running, expected finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  task automatic fill_random(input int n);
    stim_bytes.delete();
    repeat (n) stim_bytes.push_back(8'($urandom_range(0, 255)));
  endtask

  task automatic fill_scenario1();
    stim_bytes = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
  endtask

  // Reference word w: bytes 4w..4w+3 weighted by 1, 2^8, 2^16, 2^24.
  function automatic logic [31:0] model_word(input int w);
    logic [31:0] v = 0;
    for (int k = 0; k < 4; k++) v += 32'(stim_bytes[4*w + k]) << (8 * k);
    return v;
  endfunction

  function automatic logic [31:0] push_writes(input logic [DEPTH-1:0] base, input int nwords);
    logic [31:0] s = 0;
    for (int w = 0; w < nwords; w++) begin
      exp_q.push_back('{1'b0, DEPTH'((int'(base) + w) % (1 << DEPTH)), model_word(w)});
      s += model_word(w);
    end
    return s;
  endfunction

  task automatic start_load(input logic [DEPTH-1:0] base, input int count);
    load_start = 1'b1;
    load_base  = base;
    load_count = (DEPTH+1)'(count);
    @(negedge sys_clk);
    load_start = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    int waited = 0;
    repeat (gap) @(negedge sys_clk);
    rx_valid = 1'b1;
    rx_data  = b;
    #1;
    while (!rx_ready && waited < 200) begin
      @(negedge sys_clk);
      #1;
      waited++;
    end
    check_output("rx_ready_timeout", 32'(rx_ready), 32'd1);
    @(negedge sys_clk);
    rx_valid = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 500 && busy; i++) @(negedge sys_clk);
    check_output("idle_timeout", 32'(busy), 32'd0);
  endtask

  task automatic apply_stimulus(input logic [DEPTH-1:0] base, input int count, input int max_gap,
                                input bit pulse_busy_start, input bit corrupt_sum);
    logic [31:0] sum_tx;
    bit          exp_err = 1'b0;
    sum_tx = push_writes(base, count);
`ifdef PDU_IMEM_LOADER_CHECKSUM_EN
    if (corrupt_sum) begin
      sum_tx  = 32'h0;
      exp_err = 1'b1;
    end else begin
      exp_q.push_back('{1'b1, '0, '0});
    end
`else
    exp_q.push_back('{1'b1, '0, '0});
`endif
    start_load(base, count);
    check_output("error_cleared_on_start", 32'(error), 32'd0);
    if (pulse_busy_start) begin
      load_start = 1'b1;
      load_base  = base ^ 12'h5A5;
      load_count = 13'd1;
      @(negedge sys_clk);
      load_start = 1'b0;
    end
    for (int i = 0; i < 4 * count; i++) send_byte(stim_bytes[i], int'($urandom_range(0, max_gap)));
`ifdef PDU_IMEM_LOADER_CHECKSUM_EN
    for (int k = 0; k < 4; k++) send_byte(sum_tx[8*k +: 8], int'($urandom_range(0, max_gap)));
`endif
    wait_idle();
    repeat (2) @(negedge sys_clk);
    check_output("error_at_end", 32'(error), 32'(exp_err));
    check_output("scoreboard_drained", 32'(exp_q.size()), 32'd0);
  endtask

  initial begin
    #1;
    check_output("reset_rx_ready", 32'(rx_ready), 32'd0);
    check_output("reset_mem_we", 32'(mem_we), 32'd0);
    check_output("reset_busy", 32'(busy), 32'd0);
    check_output("reset_done", 32'(done), 32'd0);
    check_output("reset_error", 32'(error), 32'd0);
    check_output("reset_mem_addr", 32'(mem_addr), 32'd0);
    check_output("reset_mem_wdata", mem_wdata, 32'd0);
    repeat (3) @(negedge sys_clk);
    sys_rstn = 1'b1;
    @(negedge sys_clk);

    $display("[TB] basic two-word load");
    fill_scenario1();
    apply_stimulus(12'h010, 2, 0, 1'b0, 1'b0);

    $display("[TB] zero-count load");
    saw_ready = 1'b0;
    exp_q.push_back('{1'b1, '0, '0});
    start_load(12'h123, 0);
    check_output("count0_done_pulse", 32'(done), 32'd1);
    @(negedge sys_clk);
    check_output("count0_done_once", 32'(done), 32'd0);
    check_output("count0_busy", 32'(busy), 32'd0);
    repeat (2) @(negedge sys_clk);
    check_output("count0_rx_ready_seen", 32'(saw_ready), 32'd0);
    check_output("count0_drained", 32'(exp_q.size()), 32'd0);

    $display("[TB] address wrap");
    fill_random(8);
    apply_stimulus(12'hFFF, 2, 1, 1'b0, 1'b0);

    $display("[TB] abort after six bytes");
    fill_random(12);
    void'(push_writes(12'h200, 1));
    start_load(12'h200, 3);
    for (int i = 0; i < 6; i++) send_byte(stim_bytes[i], int'($urandom_range(0, 2)));
    load_abort = 1'b1;
    @(negedge sys_clk);
    load_abort = 1'b0;
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_error", 32'(error), 32'd1);
    repeat (4) @(negedge sys_clk);
    check_output("abort_drained", 32'(exp_q.size()), 32'd0);
    check_output("abort_error_sticky", 32'(error), 32'd1);

    $display("[TB] abort during write cycle");
    fill_random(8);
    start_load(12'h300, 2);
    for (int i = 0; i < 4; i++) send_byte(stim_bytes[i], 0);
    load_abort = 1'b1;
    @(negedge sys_clk);
    load_abort = 1'b0;
    check_output("abort_write_busy", 32'(busy), 32'd0);
    check_output("abort_write_error", 32'(error), 32'd1);
    repeat (3) @(negedge sys_clk);

    $display("[TB] gapped stream with ignored restart");
    fill_scenario1();
    apply_stimulus(12'h010, 2, 7, 1'b1, 1'b0);

`ifdef PDU_IMEM_LOADER_CHECKSUM_EN
    $display("[TB] checksum mismatch");
    fill_scenario1();
    apply_stimulus(12'h010, 2, 2, 1'b0, 1'b1);
`endif

    $display("[TB] random loads");
    for (int r = 0; r < 6; r++) begin
      int cnt = int'($urandom_range(1, 4));
      fill_random(4 * cnt);
      apply_stimulus(DEPTH'($urandom_range(0, (1 << DEPTH) - 1)), cnt, 3, r[0], 1'b0);
    end

    $display("[TB] reset during load");
    fill_random(4);
    start_load(12'h0AB, 1);
    for (int i = 0; i < 3; i++) send_byte(stim_bytes[i], 0);
    #2 sys_rstn = 1'b0;
    #1;
    check_output("midreset_busy", 32'(busy), 32'd0);
    check_output("midreset_rx_ready", 32'(rx_ready), 32'd0);
    check_output("midreset_mem_we", 32'(mem_we), 32'd0);
    check_output("midreset_mem_addr", 32'(mem_addr), 32'd0);
    check_output("midreset_mem_wdata", mem_wdata, 32'd0);
    @(negedge sys_clk);
    sys_rstn = 1'b1;
    repeat (3) @(negedge sys_clk);
    check_output("midreset_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
